// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder that reuses one 4-bit ripple stage, LSB nibble first.
// Optional signed-overflow output enabled by defining OVERFLOW_FLAG_EN.
module ripple_carry_adder_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  logic [4:0] c;
  assign c[0] = cin;
  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end
  assign cout = c[4];
endmodule

module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
`ifdef OVERFLOW_FLAG_EN
  ,
  output logic             ovf
`endif
);
  if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
    $error("nibble_serial_adder: WIDTH must be a multiple of 4 and >= 4");
  end

  localparam int NIB = WIDTH / 4;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [CW-1:0] LAST = CW'(NIB - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic [3:0]       na, nb, ns;
  logic             nc;

  assign na = a_reg[cnt*4 +: 4];
  assign nb = b_reg[cnt*4 +: 4];

  ripple_carry_adder_4bit u_rca (
    .a    (na),
    .b    (nb),
    .cin  (carry),
    .sum  (ns),
    .cout (nc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      carry <= 1'b0;
      a_reg <= '0;
      b_reg <= '0;
      sum   <= '0;
      cout  <= 1'b0;
`ifdef OVERFLOW_FLAG_EN
      ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_reg <= a;
          b_reg <= b;
          carry <= cin;
          cnt   <= '0;
          state <= RUN;
        end
        RUN: begin
          sum[cnt*4 +: 4] <= ns;
          carry           <= nc;
          cnt             <= cnt + 1'b1;
          if (cnt == LAST) begin
            cout  <= nc;
            cnt   <= '0;
`ifdef OVERFLOW_FLAG_EN
            // carry into the MSB is recoverable from the MSB's own sum bit
            ovf   <= (na[3] ^ nb[3] ^ ns[3]) ^ nc;
`endif
            state <= DONE;
          end
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder (WIDTH=16): vector table, random vs. arithmetic model, corner sequences.
module tb_nibble_serial_adder;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, cin, out_valid, out_ready, cout, busy;
  logic [15:0] a, b, sum;
`ifdef OVERFLOW_FLAG_EN
  logic        ovf;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  nibble_serial_adder #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
`ifdef OVERFLOW_FLAG_EN
    ,
    .ovf       (ovf)
`endif
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] s;
    logic        c;
    logic        v;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Waits (bounded) for out_valid, checking busy throughout; returns edges counted.
  task automatic wait_result(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      chk("busy_run", busy, 1);
      @(posedge clk); #1;
      lat++;
    end
    chk("out_valid_timeout", out_valid, 1);
  endtask

  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb, input logic tc,
                        output logic [15:0] rs, output logic rc, output logic rv);
    int lat;
    @(negedge clk);
    chk("in_ready_idle", in_ready, 1);
    in_valid = 1; a = ta; b = tb; cin = tc;
    @(posedge clk); #1;
    in_valid = 0; a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
    wait_result(lat);
    chk("latency", lat, 4);
    rs = sum; rc = cout; rv = 1'b0;
`ifdef OVERFLOW_FLAG_EN
    rv = ovf;
`endif
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    chk("out_valid_drop", out_valid, 0);
  endtask

  initial begin
    vec_t        vt[$];
    logic [15:0] rs, ra, rb;
    logic        rc, rv, rcin, ev;
    logic [16:0] full;
    int          lat;

    vt.push_back('{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0});
    vt.push_back('{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0});
    vt.push_back('{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0});
    vt.push_back('{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0});
    vt.push_back('{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0});
    vt.push_back('{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1});
    vt.push_back('{16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFE, 1'b1, 1'b0});
    vt.push_back('{16'h8000, 16'h8000, 1'b1, 16'h0001, 1'b1, 1'b1});

    rst_n = 0; in_valid = 0; out_ready = 0; a = 0; b = 0; cin = 0;
    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    @(negedge clk); rst_n = 1;

    foreach (vt[i]) begin
      run_op(vt[i].a, vt[i].b, vt[i].cin, rs, rc, rv);
      chk($sformatf("vec%0d_sum", i), rs, vt[i].s);
      chk($sformatf("vec%0d_cout", i), rc, vt[i].c);
`ifdef OVERFLOW_FLAG_EN
      chk($sformatf("vec%0d_ovf", i), rv, vt[i].v);
`endif
      chk("idle_after_hs", busy, 0);
    end

    for (int i = 0; i < 40; i++) begin
      ra = 16'($urandom); rb = 16'($urandom); rcin = 1'($urandom);
      full = 17'(ra) + 17'(rb) + 17'(rcin);
      run_op(ra, rb, rcin, rs, rc, rv);
      chk("rand_sum", rs, full[15:0]);
      chk("rand_cout", rc, full[16]);
`ifdef OVERFLOW_FLAG_EN
      ev = (ra[15] == rb[15]) && (full[15] != ra[15]);
      chk("rand_ovf", rv, ev);
`endif
    end

    // Backpressure: result must hold while a new bundle waits.
    @(negedge clk);
    in_valid = 1; a = 16'h0F0F; b = 16'h00F1; cin = 0;
    @(posedge clk); #1;
    in_valid = 0;
    wait_result(lat);
    in_valid = 1; a = 16'h1111; b = 16'h2222; cin = 0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("bp_out_valid", out_valid, 1);
      chk("bp_sum", sum, 16'h1000);
      chk("bp_cout", cout, 0);
      chk("bp_in_ready", in_ready, 0);
    end
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    chk("bp_release_valid", out_valid, 0);
    chk("bp_release_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 0;
    chk("bp_accept_busy", busy, 1);
    wait_result(lat);
    chk("bp_latency", lat, 4);
    chk("bp_next_sum", sum, 16'h3333);
    chk("bp_next_cout", cout, 0);
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;

    // Reset after two RUN edges aborts the operation immediately.
    @(negedge clk);
    in_valid = 1; a = 16'hABCD; b = 16'h1357; cin = 1;
    @(posedge clk); #1;
    in_valid = 0;
    @(posedge clk); @(posedge clk); #2;
    rst_n = 0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_sum", sum, 0);
    chk("mid_rst_cout", cout, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_busy", busy, 0);
    @(negedge clk); rst_n = 1;
    run_op(16'h00FF, 16'h0001, 1'b0, rs, rc, rv);
    chk("post_rst_sum", rs, 16'h0100);
    chk("post_rst_cout", rc, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/nibble_serial_adder.md
Name: nibble_serial_adder

Overview:
Multi-cycle WIDTH-bit adder that feeds ripple_carry_adder_4bit one nibble per clock, LSB nibble first. It registers the inter-nibble carry and assembles the full sum. Valid/ready handshakes sit on both input and output, so wide additions reuse a single 4-bit adder stage instead of a wide combinational chain.

Parameters:
WIDTH, 16, operand/sum width in bits; must be a multiple of 4 and >= 4, otherwise elaboration error

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand bundle valid
in_ready  output  1  block can accept operands
a  input  WIDTH  operand A
b  input  WIDTH  operand B
cin  input  1  carry into nibble 0
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
sum  output  WIDTH  result, registered
cout  output  1  carry out of MSB nibble, registered
busy  output  1  high in RUN or DONE

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Single ripple_carry_adder_4bit instance. Its inputs are nibble k of the latched a/b and the carry register.
- FSM states: IDLE, RUN, DONE. Nibble counter runs 0..WIDTH/4-1.
- Reset (rst_n low, any state, effective immediately):
  - state=IDLE, counter=0, carry_reg=0, a/b latches=0.
  - sum=0, cout=0, out_valid=0, busy=0.
  - in_ready=1, decoded from IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at an edge: latch a, b; carry_reg<=cin; counter<=0; go RUN.
  - sum/cout keep their last values; out_valid=0.
- RUN, each edge:
  - sum[4k+3:4k] <= adder sum; carry_reg <= adder cout; counter<=counter+1.
  - When counter==WIDTH/4-1: cout <= adder cout; go DONE.
  - in_ready=0.
- DONE:
  - out_valid=1; sum and cout held stable while out_ready=0.
  - On out_valid&&out_ready: go IDLE, out_valid drops next cycle.
  - in_ready=0; no same-cycle accept.
- Latency and throughput:
  - out_valid rises WIDTH/4 edges after the accepting edge (16-bit: 4).
  - Minimum period between accepts is WIDTH/4+2 clocks.
- Inputs a, b, cin are ignored outside the accepting edge. Changing them during RUN has no effect.
- Arithmetic: {cout,sum} = a+b+cin, unsigned, modulo 2^(WIDTH+1). No saturation.
- in_valid during RUN/DONE: not accepted. The producer must hold it until in_ready.
- Reset mid-RUN or mid-DONE: operation aborted, partial result discarded, no out_valid.

Optional Feature:
OVERFLOW_FLAG_EN
- Defined: adds output port ovf (1 bit), registered, reset 0.
- ovf is loaded with the two's-complement signed overflow (carry into MSB XOR carry out of MSB) on the final RUN edge.
- ovf is valid with out_valid and held in DONE.
- Undefined: port absent, no extra logic; all other behaviour identical.

Test Plan:
1. WIDTH=16, a=0x0000, b=0x0000, cin=0 accepted at edge T -> out_valid high after edge T+4, sum=0x0000, cout=0, busy=1 from T to handshake.
2. a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1; carry propagates through all 4 nibbles.
3. a=0x1234, b=0x4321, cin=1 -> sum=0x5556, cout=0.
4. Backpressure on result 0x0F0F+0x00F1 (sum=0x1000, cout=0):
   - Hold out_ready=0 for 3 cycles while driving a new in_valid -> out_valid, sum, cout stable; in_ready=0; new operands not accepted.
   - Raise out_ready -> IDLE and in_ready=1 the next cycle; pending operands accepted then.
5. Assert rst_n low after 2 RUN edges -> out_valid=0, sum=0, cout=0, in_ready=1 immediately.
   - After release, 0x00FF+0x0001, cin=0 -> sum=0x0100, cout=0.
6. With OVERFLOW_FLAG_EN:
   - 0x7FFF+0x0001 -> sum=0x8000, cout=0, ovf=1.
   - 0xFFFF+0xFFFF -> sum=0xFFFE, cout=1, ovf=0.
